// File: rtl/dff_pipe_vr.sv
// Registered delay pipeline of DEPTH stages with valid/ready flow control.
// Empty stages pull from upstream even while the output stalls, so internal bubbles collapse.
module dff_pipe_vr #(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter bit               CLEAR_DATA = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  // Handshake: a word moves across a port only on a rising edge where valid and ready are
  // both high; valid never waits for ready, and ready may depend combinationally on out_ready.

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [CW-1:0]    count_c;

  // A stage may advance when it is empty or everything downstream of it advances.
  always_comb begin
    logic acc;
    acc = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc    = !v[k] | acc;
      adv[k] = acc;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_src
    if (k == 0) begin : g_head
      assign src_v[k] = in_valid & !flush;
      assign src_d[k] = in_data;
    end else begin : g_body
      assign src_v[k] = v[k-1];
      assign src_d[k] = d[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (adv[k]) v[k] <= src_v[k];
      end
    end
  end

  // Data only loads alongside a valid word; a flush leaves the data registers untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (CLEAR_DATA) begin
        for (int k = 0; k < DEPTH; k++) d[k] <= RESET_VAL;
      end
    end else if (!flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (adv[k] && src_v[k]) d[k] <= src_d[k];
      end
    end
  end

  always_comb begin
    count_c = '0;
    for (int k = 0; k < DEPTH; k++) count_c = count_c + CW'(v[k]);
  end

  assign in_ready  = adv[0] & !flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign count     = count_c;

endmodule

// File: tb/tb_dff_pipe_vr.sv
// Bench for dff_pipe_vr: DEPTH=4 directed scenarios plus a DEPTH=1 random run,
// both checked against queue-based scoreboards and an occupancy model.
module tb_dff_pipe_vr;

  localparam logic [7:0] RV = 8'hA5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [2:0] count;

  logic       reset_1 = 1'b1, in_valid_1 = 1'b0, out_ready_1 = 1'b0, flush_1 = 1'b0;
  logic [7:0] in_data_1 = '0;
  logic       in_ready_1, out_valid_1;
  logic [7:0] out_data_1;
  logic [0:0] count_1;

  dff_pipe_vr #(.WIDTH(8), .DEPTH(4), .RESET_VAL(RV), .CLEAR_DATA(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .flush(flush),
    .count(count)
  );

  dff_pipe_vr #(.WIDTH(8), .DEPTH(1), .RESET_VAL(RV), .CLEAR_DATA(1'b1)) dut_1 (
    .clk(clk), .reset(reset_1), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .in_data(in_data_1), .out_valid(out_valid_1), .out_ready(out_ready_1),
    .out_data(out_data_1), .flush(flush_1), .count(count_1)
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int cyc      = 0;
  bit lat_chk  = 1'b0;
  int occ      = 0;
  logic [7:0] exp_q[$];
  int         exp_t[$];

  int occ1 = 0;
  bit pend1 = 1'b0;
  logic [7:0] pend1_d;
  logic [7:0] exp1_q[$];

  // Scoreboard for the DEPTH=4 instance.
  always @(negedge clk) begin
    logic [7:0] ed;
    int         et;
    logic       er;
    cyc++;
    if (reset) begin
      exp_q.delete(); exp_t.delete(); occ = 0;
    end else begin
      vec_cnt++;
      if (count !== 3'(occ)) begin
        miss_cnt++; $display("FAIL count_model: got %0d expected %0d", count, occ);
      end
      er = !flush && (out_ready || occ < 4);
      vec_cnt++;
      if (in_ready !== er) begin
        miss_cnt++; $display("FAIL in_ready_model: got %b expected %b", in_ready, er);
      end
      if (out_valid === 1'b1 && out_ready) begin
        vec_cnt++;
        if (exp_q.size() == 0) begin
          miss_cnt++; $display("FAIL sb_unexpected: got %h expected no word", out_data);
        end else begin
          ed = exp_q.pop_front(); et = exp_t.pop_front();
          if (out_data !== ed) begin
            miss_cnt++; $display("FAIL sb_data: got %h expected %h", out_data, ed);
          end
          if (lat_chk) begin
            vec_cnt++;
            if (cyc - et != 4) begin
              miss_cnt++; $display("FAIL sb_latency: got %0d expected 4", cyc - et);
            end
          end
          occ--;
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(in_data); exp_t.push_back(cyc); occ++;
      end
      if (flush) begin
        exp_q.delete(); exp_t.delete(); occ = 0;
      end
    end
  end

  // Scoreboard for the DEPTH=1 instance.
  always @(negedge clk) begin
    logic [7:0] ed;
    logic       er;
    if (reset_1) begin
      exp1_q.delete(); occ1 = 0; pend1 = 1'b0;
    end else begin
      if (pend1) begin
        vec_cnt++;
        if (out_valid_1 !== 1'b1 || out_data_1 !== pend1_d) begin
          miss_cnt++;
          $display("FAIL d1_latency: got v=%b %h expected v=1 %h", out_valid_1, out_data_1, pend1_d);
        end
        pend1 = 1'b0;
      end
      vec_cnt++;
      if (count_1 !== 1'(occ1)) begin
        miss_cnt++; $display("FAIL d1_count: got %0d expected %0d", count_1, occ1);
      end
      er = (occ1 == 0) || out_ready_1;
      vec_cnt++;
      if (in_ready_1 !== er) begin
        miss_cnt++; $display("FAIL d1_in_ready: got %b expected %b", in_ready_1, er);
      end
      if (out_valid_1 === 1'b1 && out_ready_1) begin
        vec_cnt++;
        if (exp1_q.size() == 0) begin
          miss_cnt++; $display("FAIL d1_unexpected: got %h expected no word", out_data_1);
        end else begin
          ed = exp1_q.pop_front();
          if (out_data_1 !== ed) begin
            miss_cnt++; $display("FAIL d1_data: got %h expected %h", out_data_1, ed);
          end
          occ1--;
        end
      end
      if (in_valid_1 && in_ready_1 === 1'b1) begin
        exp1_q.push_back(in_data_1); occ1++; pend1 = 1'b1; pend1_d = in_data_1;
      end
    end
  end

  task automatic drain(input string name);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    vec_cnt++;
    if (exp_q.size() != 0) begin
      miss_cnt++; $display("FAIL %s_drain: got %0d words left expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (out_valid !== 1'b0) begin miss_cnt++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    vec_cnt++;
    if (count !== 3'd0) begin miss_cnt++; $display("FAIL rst_count: got %0d expected 0", count); end
    vec_cnt++;
    if (in_ready !== 1'b1) begin miss_cnt++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    vec_cnt++;
    if (out_data !== RV) begin miss_cnt++; $display("FAIL rst_out_data: got %h expected %h", out_data, RV); end
  endtask

  task automatic test_stream();
    lat_chk = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1 in_valid = 1'b1; in_data = 8'(i);
      @(negedge clk);
      if (i >= 5) begin
        vec_cnt++;
        if (count !== 3'd4) begin miss_cnt++; $display("FAIL stream_count: got %0d expected 4", count); end
        vec_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'(i - 4)) begin
          miss_cnt++; $display("FAIL stream_out: got v=%b %h expected v=1 %h", out_valid, out_data, 8'(i - 4));
        end
      end
    end
    @(posedge clk);
    #1 drain("stream");
    lat_chk = 1'b0;
  endtask

  task automatic test_bubble();
    logic [7:0] dat [5] = '{8'h10, 8'h00, 8'h11, 8'h00, 8'h12};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 in_valid = (i % 2 == 0); in_data = dat[i];
      @(negedge clk);
      if (in_valid) begin
        vec_cnt++;
        if (in_ready !== 1'b1) begin miss_cnt++; $display("FAIL bubble_accept: got %b expected 1", in_ready); end
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    vec_cnt++;
    if (count !== 3'd3) begin miss_cnt++; $display("FAIL bubble_count3: got %0d expected 3", count); end
    vec_cnt++;
    if (out_valid !== 1'b1 || out_data !== 8'h10) begin
      miss_cnt++; $display("FAIL bubble_head: got v=%b %h expected v=1 10", out_valid, out_data);
    end
    @(posedge clk);
    #1 in_valid = 1'b1; in_data = 8'h13;
    @(posedge clk);
    #1 in_data = 8'h14;
    @(negedge clk);
    vec_cnt++;
    if (count !== 3'd4) begin miss_cnt++; $display("FAIL bubble_full: got %0d expected 4", count); end
    vec_cnt++;
    if (in_ready !== 1'b0) begin miss_cnt++; $display("FAIL bubble_stall: got %b expected 0", in_ready); end
    @(posedge clk);
    #1 drain("bubble");
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 in_valid = 1'b1; in_data = 8'h20 + 8'(i);
    end
    @(posedge clk);
    #1 in_data = 8'h55; flush = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (count !== 3'd4) begin miss_cnt++; $display("FAIL flush_pre_count: got %0d expected 4", count); end
    vec_cnt++;
    if (in_ready !== 1'b0) begin miss_cnt++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      miss_cnt++; $display("FAIL flush_empty: got count=%0d v=%b expected count=0 v=0", count, out_valid);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (out_valid !== 1'b0) begin miss_cnt++; $display("FAIL flush_leak: got %h expected no word", out_data); end
    end
  endtask

  task automatic test_reset_midstream();
    int first;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 in_valid = 1'b1; in_data = 8'h30 + 8'(i);
    end
    @(posedge clk);
    #1 in_valid = 1'b0; reset = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; flush = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== RV) begin
      miss_cnt++;
      $display("FAIL rstmid_state: got count=%0d v=%b %h expected count=0 v=0 %h", count, out_valid, out_data, RV);
    end
    lat_chk = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b1; in_data = 8'h77;
    @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    first = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (first < 0 && out_valid === 1'b1) begin
        first = k;
        vec_cnt++;
        if (out_data !== 8'h77) begin miss_cnt++; $display("FAIL rstmid_data: got %h expected 77", out_data); end
      end
    end
    vec_cnt++;
    if (first != 4) begin miss_cnt++; $display("FAIL rstmid_latency: got %0d expected 4", first); end
    lat_chk = 1'b0;
  endtask

  task automatic test_depth1_random();
    repeat (2) @(posedge clk);
    #1 reset_1 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1 in_valid_1 = 1'($urandom_range(0, 1));
      in_data_1   = 8'($urandom_range(0, 255));
      out_ready_1 = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1 in_valid_1 = 1'b0; out_ready_1 = 1'b1;
    repeat (5) @(negedge clk);
    vec_cnt++;
    if (exp1_q.size() != 0) begin
      miss_cnt++; $display("FAIL d1_drain: got %0d words left expected 0", exp1_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_bubble();
    test_flush();
    test_reset_midstream();
    test_depth1_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
